// File: rtl/uart_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_ctrl_pkg
//  Description : Shared definitions for the uart command-frame controller:
//                command/status codes, FSM state encoding, frame checksum.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_frame_ctrl_pkg;

  // Command codes carried in the CMD byte of a command frame
  localparam logic [7:0] CMD_WRITE      = 8'h57;
  localparam logic [7:0] CMD_READ       = 8'h52;

  // Status codes returned in the STATUS byte of a response frame
  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_BAD_CHK = 8'h01;
  localparam logic [7:0] STATUS_BAD_CMD = 8'h02;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_POP     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_EXEC    = 3'd3,
    ST_RDWAIT  = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

  // Command-frame checksum: XOR of CMD, ADDR and DATA
  function automatic logic [7:0] frame_checksum(input logic [7:0] cmd,
                                                input logic [7:0] addr,
                                                input logic [7:0] data);
    return cmd ^ addr ^ data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_ctrl_if
//  Description : Bundle of the frame controller's FIFO, register-bus and
//                status signals. Names carry the direction seen by the
//                controller (i_ = into controller, o_ = out of controller).
//  Ports       : i_enable, rx FIFO (i_rx_data, i_rx_empty, o_read_rx_data),
//                tx FIFO (o_tx_data, i_tx_full, o_write_tx_data),
//                register bus (o_reg_addr, o_reg_wdata, o_reg_we, o_reg_re,
//                i_reg_rdata), status (o_busy, o_err_count)
//                modport slave  : the frame controller
//                modport master : the FIFO / register / host environment
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_frame_ctrl_if;
  logic       i_enable;
  logic [7:0] i_rx_data;
  logic       i_rx_empty;
  logic       o_read_rx_data;
  logic [7:0] o_tx_data;
  logic       i_tx_full;
  logic       o_write_tx_data;
  logic [7:0] o_reg_addr;
  logic [7:0] o_reg_wdata;
  logic       o_reg_we;
  logic       o_reg_re;
  logic [7:0] i_reg_rdata;
  logic       o_busy;
  logic [7:0] o_err_count;

  modport slave (
    input  i_enable, i_rx_data, i_rx_empty, i_tx_full, i_reg_rdata,
    output o_read_rx_data, o_tx_data, o_write_tx_data,
           o_reg_addr, o_reg_wdata, o_reg_we, o_reg_re, o_busy, o_err_count
  );

  modport master (
    output i_enable, i_rx_data, i_rx_empty, i_tx_full, i_reg_rdata,
    input  o_read_rx_data, o_tx_data, o_write_tx_data,
           o_reg_addr, o_reg_wdata, o_reg_we, o_reg_re, o_busy, o_err_count
  );
endinterface
`default_nettype wire

// File: rtl/uart_frame_ctrl_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_ctrl_timer
//  Description : Inter-byte timeout counter. Counts cycles while i_run is
//                high, saturates at TIMEOUT_CYCLES and flags o_expired.
//  Ports       : clk, rst_n (async, active-low)
//                i_clear   - zero the counter (priority over i_run)
//                i_run     - count one cycle
//                o_expired - counter has reached TIMEOUT_CYCLES
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_ctrl_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_count;
  logic             w_at_limit;

  assign w_at_limit = (r_count == CNT_W'(TIMEOUT_CYCLES));
  assign o_expired  = w_at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_run && !w_at_limit) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_ctrl
//  Description : Command-frame sequencer between the uart FIFOs and an 8-bit
//                register bus. Hunts for SYNC_CMD,CMD,ADDR,DATA,CHK frames,
//                executes a register write/read and answers with
//                SYNC_RSP,STATUS,RDATA,STATUS^RDATA.
//  Ports       : clk, rst_n (async, active-low)
//                bus (uart_frame_ctrl_if.slave) - enable, rx/tx FIFO,
//                register bus, busy and saturating error count
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_ctrl
  import uart_frame_ctrl_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] SYNC_CMD       = 8'hA5,
  parameter logic [7:0] SYNC_RSP       = 8'h5A
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_frame_ctrl_if.slave  bus
);

  state_t     r_state;
  logic [2:0] r_idx;        // 0 = hunting for sync, 1..4 = CMD..CHK expected
  logic [7:0] r_cmd;
  logic [7:0] r_addr;
  logic [7:0] r_data;
  logic [7:0] r_chk;
  logic [7:0] r_status;
  logic [7:0] r_rdata;
  logic [1:0] r_ridx;       // response byte currently presented on tx_data
  logic       r_rd;
  logic       r_wr;
  logic       r_we;
  logic       r_re;
  logic [7:0] r_tx_data;
  logic [7:0] r_reg_addr;
  logic [7:0] r_reg_wdata;
  logic [7:0] r_err_count;

  logic       w_en;
  logic [7:0] w_err_inc;
  logic [1:0] w_next_ridx;
  logic [7:0] w_next_byte;
  logic       w_tmr_clear;
  logic       w_tmr_run;
  logic       w_tmr_expired;

  assign w_en      = bus.i_enable;
  assign w_err_inc = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

  always_comb begin
    w_next_ridx = r_ridx + 2'd1;
    case (w_next_ridx)
      2'd0:    w_next_byte = SYNC_RSP;
      2'd1:    w_next_byte = r_status;
      2'd2:    w_next_byte = r_rdata;
      default: w_next_byte = r_status ^ r_rdata;
    endcase
  end

  // Timer only advances while a frame is open and the rx FIFO is starving us
  assign w_tmr_clear = w_en && ((r_state == ST_HUNT) || (r_state == ST_CAPTURE));
  assign w_tmr_run   = w_en && (r_state == ST_POP) && !r_rd &&
                       bus.i_rx_empty && (r_idx != 3'd0);

  uart_frame_ctrl_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_tmr_clear),
    .i_run     (w_tmr_run),
    .o_expired (w_tmr_expired)
  );

  // Strobes are gated by enable so a pulse caught by a disable is not lost:
  // the FSM freezes with the strobe register set and fires it on re-enable.
  assign bus.o_read_rx_data  = r_rd & w_en;
  assign bus.o_write_tx_data = r_wr & w_en;
  assign bus.o_reg_we        = r_we & w_en;
  assign bus.o_reg_re        = r_re & w_en;
  assign bus.o_tx_data       = r_tx_data;
  assign bus.o_reg_addr      = r_reg_addr;
  assign bus.o_reg_wdata     = r_reg_wdata;
  assign bus.o_busy          = (r_state != ST_HUNT);
  assign bus.o_err_count     = r_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_HUNT;
      r_idx       <= 3'd0;
      r_cmd       <= 8'h00;
      r_addr      <= 8'h00;
      r_data      <= 8'h00;
      r_chk       <= 8'h00;
      r_status    <= 8'h00;
      r_rdata     <= 8'h00;
      r_ridx      <= 2'd0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_tx_data   <= 8'h00;
      r_reg_addr  <= 8'h00;
      r_reg_wdata <= 8'h00;
      r_err_count <= 8'h00;
    end else if (w_en) begin
      r_we <= 1'b0;
      case (r_state)
        ST_HUNT: begin
          r_idx <= 3'd0;
          if (!bus.i_rx_empty) begin
            r_rd    <= 1'b1;
            r_state <= ST_POP;
          end
        end

        // r_rd high: the pop is on the bus this cycle, data lands next cycle.
        // r_rd low: waiting for the next byte of an open frame.
        ST_POP: begin
          if (r_rd) begin
            r_rd    <= 1'b0;
            r_state <= ST_CAPTURE;
          end else if (!bus.i_rx_empty) begin
            r_rd <= 1'b1;
          end else if (w_tmr_expired) begin
            r_err_count <= w_err_inc;
            r_idx       <= 3'd0;
            r_state     <= ST_HUNT;
          end
        end

        ST_CAPTURE: begin
          case (r_idx)
            3'd0: begin
              if (bus.i_rx_data == SYNC_CMD) begin
                r_idx   <= 3'd1;
                r_state <= ST_POP;
              end else begin
                r_state <= ST_HUNT;
              end
            end
            3'd1: begin
              r_cmd   <= bus.i_rx_data;
              r_idx   <= 3'd2;
              r_state <= ST_POP;
            end
            3'd2: begin
              r_addr  <= bus.i_rx_data;
              r_idx   <= 3'd3;
              r_state <= ST_POP;
            end
            3'd3: begin
              r_data  <= bus.i_rx_data;
              r_idx   <= 3'd4;
              r_state <= ST_POP;
            end
            3'd4: begin
              r_chk   <= bus.i_rx_data;
              r_state <= ST_EXEC;
            end
            default: r_state <= ST_HUNT;
          endcase
        end

        ST_EXEC: begin
          r_idx <= 3'd0;
          if (frame_checksum(r_cmd, r_addr, r_data) != r_chk) begin
            r_status    <= STATUS_BAD_CHK;
            r_rdata     <= 8'h00;
            r_err_count <= w_err_inc;
            r_tx_data   <= SYNC_RSP;
            r_ridx      <= 2'd0;
            r_state     <= ST_RESP;
          end else if (r_cmd == CMD_WRITE) begin
            r_we        <= 1'b1;
            r_reg_addr  <= r_addr;
            r_reg_wdata <= r_data;
            r_status    <= STATUS_OK;
            r_rdata     <= r_data;
            r_tx_data   <= SYNC_RSP;
            r_ridx      <= 2'd0;
            r_state     <= ST_RESP;
          end else if (r_cmd == CMD_READ) begin
            r_re       <= 1'b1;
            r_reg_addr <= r_addr;
            r_state    <= ST_RDWAIT;
          end else begin
            r_status    <= STATUS_BAD_CMD;
            r_rdata     <= 8'h00;
            r_err_count <= w_err_inc;
            r_tx_data   <= SYNC_RSP;
            r_ridx      <= 2'd0;
            r_state     <= ST_RESP;
          end
        end

        // First cycle carries the read strobe, read data is taken on the next
        ST_RDWAIT: begin
          if (r_re) begin
            r_re <= 1'b0;
          end else begin
            r_rdata   <= bus.i_reg_rdata;
            r_status  <= STATUS_OK;
            r_tx_data <= SYNC_RSP;
            r_ridx    <= 2'd0;
            r_state   <= ST_RESP;
          end
        end

        // Each byte: push when tx has room, then load the next byte
        ST_RESP: begin
          if (r_wr) begin
            r_wr <= 1'b0;
            if (r_ridx == 2'd3) begin
              r_state <= ST_HUNT;
            end else begin
              r_ridx    <= w_next_ridx;
              r_tx_data <= w_next_byte;
            end
          end else if (!bus.i_tx_full) begin
            r_wr <= 1'b1;
          end
        end

        default: r_state <= ST_HUNT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_frame_ctrl
//  Description : Self-checking bench for uart_frame_ctrl. Models the rx/tx
//                FIFOs (1-cycle read latency) and the register bus, and
//                predicts every response frame from the command-frame rules.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_ctrl;

  localparam int TO = 50;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_frame_ctrl_if bus();

  uart_frame_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .SYNC_CMD       (8'hA5),
    .SYNC_RSP       (8'h5A)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Environment state: rx stream written by stimulus, consumed by FIFO model
  logic [7:0] rx_stream[$];
  int         rx_ptr        = 0;
  logic [7:0] tx_log[$];
  int         we_cnt        = 0;
  int         re_cnt        = 0;
  int         wr_full_cnt   = 0;
  int         pop_empty_cnt = 0;
  logic [7:0] we_addr       = 8'h00;
  logic [7:0] we_data       = 8'h00;
  logic [7:0] re_addr       = 8'h00;

  int         n_tests       = 0;
  int         n_fail        = 0;
  int         model_err     = 0;
  logic [7:0] model_addr    = 8'h00;
  logic [7:0] model_wdata   = 8'h00;

  always @(posedge clk) begin
    automatic int avail = rx_stream.size() - rx_ptr;
    if (bus.o_read_rx_data) begin
      if (avail == 0) begin
        pop_empty_cnt <= pop_empty_cnt + 1;
      end else begin
        bus.i_rx_data <= rx_stream[rx_ptr];
        rx_ptr        <= rx_ptr + 1;
        avail         = avail - 1;
      end
    end
    bus.i_rx_empty <= (avail == 0);
    if (bus.o_write_tx_data) begin
      tx_log.push_back(bus.o_tx_data);
      if (bus.i_tx_full) wr_full_cnt <= wr_full_cnt + 1;
    end
    if (bus.o_reg_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= bus.o_reg_addr;
      we_data <= bus.o_reg_wdata;
    end
    if (bus.o_reg_re) begin
      re_cnt  <= re_cnt + 1;
      re_addr <= bus.o_reg_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: what the host should get back for a given command frame
  function automatic void model(input logic [7:0] cmd, input logic [7:0] addr,
                                input logic [7:0] data, input logic [7:0] cs,
                                input logic [7:0] rdv,
                                output logic [7:0] st, output logic [7:0] rv);
    if ((cmd ^ addr ^ data) != cs) begin
      st = 8'h01; rv = 8'h00;
    end else if (cmd == 8'h57) begin
      st = 8'h00; rv = data;
    end else if (cmd == 8'h52) begin
      st = 8'h00; rv = rdv;
    end else begin
      st = 8'h02; rv = 8'h00;
    end
  endfunction

  task automatic expect_frame(input string tag, input logic [7:0] cmd, input logic [7:0] addr,
                              input logic [7:0] data, input logic [7:0] cs, input logic [7:0] rdv,
                              input int ng, input logic [7:0] g0, input logic [7:0] g1,
                              input bit dis, input int full_cyc);
    logic [7:0] st, rv;
    logic [7:0] exp_tx[4];
    int tx0, we0, re0, ptr0;
    bit is_wr, is_rd;
    model(cmd, addr, data, cs, rdv, st, rv);
    exp_tx[0] = 8'h5A; exp_tx[1] = st; exp_tx[2] = rv; exp_tx[3] = st ^ rv;
    is_wr = (st == 8'h00) && (cmd == 8'h57);
    is_rd = (st == 8'h00) && (cmd == 8'h52);
    tx0 = tx_log.size(); we0 = we_cnt; re0 = re_cnt; ptr0 = rx_ptr;
    bus.i_reg_rdata = rdv;
    @(negedge clk);
    if (dis) bus.i_enable = 1'b0;
    if (ng > 0) rx_stream.push_back(g0);
    if (ng > 1) rx_stream.push_back(g1);
    rx_stream.push_back(8'hA5);
    rx_stream.push_back(cmd);
    rx_stream.push_back(addr);
    rx_stream.push_back(data);
    rx_stream.push_back(cs);
    if (dis) begin
      repeat (10) @(negedge clk);
      chk({tag, "_frozen_pops"}, rx_ptr - ptr0, 0);
      chk({tag, "_frozen_busy"}, bus.o_busy, 0);
      bus.i_enable = 1'b1;
    end
    if (full_cyc > 0) begin
      for (int i = 0; i < 300 && tx_log.size() == tx0; i++) @(negedge clk);
      bus.i_tx_full = 1'b1;
      repeat (full_cyc) @(negedge clk);
      chk({tag, "_held_while_full"}, tx_log.size() - tx0, 1);
      bus.i_tx_full = 1'b0;
    end
    for (int i = 0; i < 300 && tx_log.size() < tx0 + 4; i++) @(negedge clk);
    for (int i = 0; i < 20 && bus.o_busy; i++) @(negedge clk);
    chk({tag, "_tx_count"}, tx_log.size() - tx0, 4);
    for (int k = 0; k < 4; k++)
      if (tx_log.size() > tx0 + k)
        chk($sformatf("%s_tx%0d", tag, k), tx_log[tx0 + k], exp_tx[k]);
    if (st != 8'h00) model_err = (model_err >= 255) ? 255 : model_err + 1;
    if (is_wr || is_rd) model_addr = addr;
    if (is_wr) model_wdata = data;
    chk({tag, "_we_pulses"}, we_cnt - we0, is_wr ? 1 : 0);
    chk({tag, "_re_pulses"}, re_cnt - re0, is_rd ? 1 : 0);
    if (is_wr) begin
      chk({tag, "_we_addr"}, we_addr, addr);
      chk({tag, "_we_data"}, we_data, data);
    end
    if (is_rd) chk({tag, "_re_addr"}, re_addr, addr);
    chk({tag, "_err_count"}, bus.o_err_count, model_err);
    chk({tag, "_busy"}, bus.o_busy, 0);
    chk({tag, "_reg_addr_hold"}, bus.o_reg_addr, model_addr);
    chk({tag, "_reg_wdata_hold"}, bus.o_reg_wdata, model_wdata);
    chk({tag, "_no_push_when_full"}, wr_full_cnt, 0);
    chk({tag, "_no_pop_when_empty"}, pop_empty_cnt, 0);
    chk({tag, "_rx_drained"}, rx_ptr, rx_stream.size());
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_read"}, bus.o_read_rx_data, 0);
    chk({tag, "_write"}, bus.o_write_tx_data, 0);
    chk({tag, "_we"}, bus.o_reg_we, 0);
    chk({tag, "_re"}, bus.o_reg_re, 0);
    chk({tag, "_busy"}, bus.o_busy, 0);
    chk({tag, "_err"}, bus.o_err_count, 0);
    chk({tag, "_tx_data"}, bus.o_tx_data, 0);
    chk({tag, "_reg_addr"}, bus.o_reg_addr, 0);
    chk({tag, "_reg_wdata"}, bus.o_reg_wdata, 0);
  endtask

  initial begin
    int tx0, we0, waited;
    logic [7:0] c, a, d, cs, rdv, g0, g1;
    bus.i_enable    = 1'b1;
    bus.i_tx_full   = 1'b0;
    bus.i_reg_rdata = 8'h00;
    rst_n           = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    expect_frame("t1_write",   8'h57, 8'h10, 8'h3C, 8'h7B, 8'h00, 0, 8'h00, 8'h00, 0, 0);
    expect_frame("t2_read",    8'h52, 8'h10, 8'h00, 8'h42, 8'h99, 0, 8'h00, 8'h00, 0, 0);
    expect_frame("t3_badchk",  8'h57, 8'h10, 8'h3C, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0);
    expect_frame("t3_badcmd",  8'h41, 8'h10, 8'h3C, 8'h6D, 8'h00, 0, 8'h00, 8'h00, 0, 0);
    expect_frame("t4_garbage", 8'h57, 8'h10, 8'h3C, 8'h7B, 8'h00, 2, 8'h11, 8'h22, 0, 0);

    // Partial frame then silence: must be dropped after the inter-byte limit
    tx0 = tx_log.size(); we0 = we_cnt;
    @(negedge clk);
    rx_stream.push_back(8'hA5);
    rx_stream.push_back(8'h57);
    repeat (20) @(negedge clk);
    chk("to_busy_midway", bus.o_busy, 1);
    waited = 20;
    for (int i = 0; i < 100 && bus.o_busy; i++) begin
      @(negedge clk);
      waited++;
    end
    chk("to_back_to_hunt", bus.o_busy, 0);
    chk("to_latency_window", (waited >= TO) && (waited <= TO + 20), 1);
    model_err = model_err + 1;
    chk("to_err_count", bus.o_err_count, model_err);
    chk("to_no_tx", tx_log.size() - tx0, 0);
    chk("to_no_we", we_cnt - we0, 0);

    expect_frame("t5_txfull", 8'h57, 8'h10, 8'h3C, 8'h7B, 8'h00, 0, 8'h00, 8'h00, 0, 20);
    expect_frame("en_hold",   8'h57, 8'h22, 8'h5E, 8'h2B, 8'h00, 0, 8'h00, 8'h00, 1, 0);

    // Reset while a response is stalled behind a full tx FIFO
    tx0 = tx_log.size();
    @(negedge clk);
    rx_stream.push_back(8'hA5);
    rx_stream.push_back(8'h57);
    rx_stream.push_back(8'h10);
    rx_stream.push_back(8'h3C);
    rx_stream.push_back(8'h7B);
    for (int i = 0; i < 300 && tx_log.size() == tx0; i++) @(negedge clk);
    bus.i_tx_full = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_resp_in_progress", bus.o_busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_resp_reset");
    model_err = 0; model_addr = 8'h00; model_wdata = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_tx_full = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_resp_abandoned", tx_log.size() - tx0, 1);
    expect_frame("post_reset", 8'h57, 8'h10, 8'h3C, 8'h7B, 8'h00, 0, 8'h00, 8'h00, 0, 0);

    for (int f = 0; f < 12; f++) begin
      automatic int kind = $urandom_range(0, 3);
      a   = 8'($urandom);
      d   = 8'($urandom);
      rdv = 8'($urandom);
      g0  = 8'($urandom);
      g1  = 8'($urandom);
      if (g0 == 8'hA5) g0 = 8'h00;
      if (g1 == 8'hA5) g1 = 8'hFF;
      case (kind)
        0: c = 8'h57;
        1: c = 8'h52;
        2: c = ($urandom_range(0, 1) != 0) ? 8'h57 : 8'h52;
        default: begin
          c = 8'($urandom);
          while (c == 8'h57 || c == 8'h52) c = 8'($urandom);
        end
      endcase
      cs = c ^ a ^ d;
      if (kind == 2) cs = cs ^ 8'(1 << $urandom_range(0, 7));
      expect_frame($sformatf("rnd%0d", f), c, a, d, cs, rdv,
                   $urandom_range(0, 2), g0, g1, 0, ($urandom_range(0, 1) != 0) ? 5 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
